// File: rtl/conv_output_drain.sv
// conv_output_drain: drains the output feature banks bank-major after a layer
// completes and serialises the words onto a valid/ready stream. A two-entry
// FIFO absorbs the one-cycle BRAM read latency so backpressure never loses or
// repeats a word.
module conv_output_drain #(
    parameter int DATA_WIDTH        = 32,
    parameter int OUTPUT_BRAM_NUM   = 4,
    parameter int OUTPUT_BRAM_DEPTH = 1024,
    parameter int ADDR_WIDTH        = $clog2(OUTPUT_BRAM_DEPTH),
    parameter int BANK_WIDTH        = $clog2(OUTPUT_BRAM_NUM)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [0:0]            o_renable [OUTPUT_BRAM_NUM],
    output logic [ADDR_WIDTH-1:0] o_raddress,
    input  logic [DATA_WIDTH-1:0] i_bram_data [OUTPUT_BRAM_NUM],
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(OUTPUT_BRAM_DEPTH);
    localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(OUTPUT_BRAM_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    // Requests beyond the bank depth are clamped to a full bank.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > DEPTH_CNT) ? DEPTH_CNT : c;
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [BANK_WIDTH-1:0]   bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    // Read in flight: issued last cycle, data arrives on i_bram_data this cycle.
    logic                    infl_q;
    logic [BANK_WIDTH-1:0]   infl_bank_q;
    logic                    infl_last_q;

    // Two-entry FIFO holding read data until the stream accepts it.
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q, occ_d;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    end_of_bank;
    logic                    last_read;
    logic [CNT_W-1:0]        start_count;

    // Issue and handshake decisions; a read is allowed only while the FIFO
    // plus the in-flight slot still has room after this cycle's pop.
    always_comb begin
        pop         = (occ_q != 2'd0) && i_tready;
        push        = infl_q;
        issue       = (state_q == S_READ) &&
                      (({1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop}) < 3'd2);
        end_of_bank = ({1'b0, addr_q} == (count_q - CNT_W'(1)));
        last_read   = end_of_bank && (bank_q == LAST_BANK);
        start_count = clamp_count(i_word_count);
    end

    // Next-state logic for the drain FSM and its bank/address walk.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    count_d = start_count;
                    bank_d  = '0;
                    addr_d  = '0;
                    state_d = (start_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (end_of_bank) begin
                        addr_d = '0;
                        bank_d = bank_q + BANK_WIDTH'(1);
                        if (last_read) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Exit as soon as the final beat is being accepted so o_done
                // follows the last beat by one cycle.
                if (!infl_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy bookkeeping; push and pop may coincide at any fill level.
    always_comb begin
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state, in-flight tracking and FIFO pointers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            bank_q      <= '0;
            addr_q      <= '0;
            infl_q      <= 1'b0;
            infl_bank_q <= '0;
            infl_last_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            infl_q      <= issue;
            infl_bank_q <= bank_q;
            infl_last_q <= last_read;
            occ_q       <= occ_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO storage: captures the bank word one cycle after its read.
    always_ff @(posedge i_clock) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= i_bram_data[infl_bank_q];
            fifo_last_q[wr_ptr_q] <= infl_last_q;
        end
    end

    // Output drive: BRAM enables follow the issue decision, the stream comes
    // straight from the FIFO head and is forced to zero while empty.
    always_comb begin
        for (int b = 0; b < OUTPUT_BRAM_NUM; b++) begin
            o_renable[b] = issue && (bank_q == BANK_WIDTH'(b));
        end
        o_raddress = addr_q;
        o_busy     = (state_q != S_IDLE);
        o_done     = (state_q == S_DONE);
        o_tvalid   = (occ_q != 2'd0);
        o_tdata    = o_tvalid ? fifo_data_q[rd_ptr_q] : '0;
        o_tlast    = o_tvalid && fifo_last_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_conv_output_drain.sv
// Bench for conv_output_drain: table of drain scenarios plus hand-written
// reset-abort and start-while-busy sequences, against a registered BRAM model.
module tb_conv_output_drain;

    localparam int NB = 4;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic [10:0] i_word_count;
    logic        o_busy;
    logic        o_done;
    logic [0:0]  o_renable [NB];
    logic [9:0]  o_raddress;
    logic [31:0] bram_data [NB];
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_tlast;

    conv_output_drain dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_renable    (o_renable),
        .o_raddress   (o_raddress),
        .i_bram_data  (bram_data),
        .o_tdata      (o_tdata),
        .o_tvalid     (o_tvalid),
        .i_tready     (i_tready),
        .o_tlast      (o_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Banks hold (bank<<16)|addr; cycles without a read present garbage.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (o_renable[b][0]) bram_data[b] <= (32'(b) << 16) | 32'(o_raddress);
            else                 bram_data[b] <= 32'hDEAD0000 | 32'(b);
        end
    end

    int checks = 0;
    int passed = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Per-drain bookkeeping
    int cyc, wc, total;
    int beats, reads, tlast_cnt, done_cnt;
    int first_ren, first_v, last_beat, done_cyc;
    int extra_start = -100;
    int reset_at    = -100;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    function automatic int exp_word(int k);
        if (wc == 0) return 0;
        return ((k / wc) << 16) | (k % wc);
    endfunction

    task automatic init_counts(input int w);
        wc = w; total = w * NB; cyc = 0;
        beats = 0; reads = 0; tlast_cnt = 0; done_cnt = 0;
        first_ren = -1; first_v = -1; last_beat = -1; done_cyc = -1;
        prev_stall = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later.
    task automatic step(input logic rdy);
        int nren, rbank;
        @(negedge clk);
        i_tready = rdy;
        i_start  = (cyc + 1 == extra_start);
        i_reset  = (cyc + 1 == reset_at);
        #1;
        cyc++;
        nren = 0; rbank = 0;
        for (int b = 0; b < NB; b++) begin
            if (o_renable[b][0]) begin nren++; rbank = b; end
        end
        if (nren > 0) begin
            check("ren_onehot", nren, 1);
            check("ren_bank", rbank, (wc > 0) ? reads / wc : 0);
            check("raddr", int'(o_raddress), (wc > 0) ? reads % wc : 0);
            if (first_ren < 0) first_ren = cyc;
            reads++;
        end
        if (prev_stall) begin
            check("hold_valid", int'(o_tvalid), 1);
            check("hold_data", int'(o_tdata), int'(prev_data));
            check("hold_last", int'(o_tlast), int'(prev_last));
        end
        if (o_tvalid && i_tready) begin
            check("tdata", int'(o_tdata), exp_word(beats));
            check("tlast", int'(o_tlast), int'(beats == total - 1));
            if (o_tlast) tlast_cnt++;
            if (first_v < 0) first_v = cyc;
            last_beat = cyc;
            beats++;
        end
        if (o_tvalid && !i_tready) check("readahead", int'((reads - beats) <= 2), 1);
        if (o_done) begin
            check("busy_with_done", int'(o_busy), 1);
            done_cnt++;
            done_cyc = cyc;
        end
        prev_stall = o_tvalid && !i_tready;
        prev_data  = o_tdata;
        prev_last  = o_tlast;
    endtask

    task automatic start_pulse(input int cnt, input int w);
        @(negedge clk);
        i_reset = 1'b0; i_start = 1'b1; i_word_count = 11'(cnt); i_tready = 1'b1;
        #1;
        init_counts(w);
    endtask

    // mode 0: ready high; 1: ready toggles; 2: 50-cycle stall mid-bank2
    task automatic run_drain(input int cnt, input int w, input int mode);
        int stall_start;
        logic rdy;
        stall_start = -1;
        start_pulse(cnt, w);
        while (done_cnt == 0 && cyc < 20000) begin
            case (mode)
                1:       rdy = ((cyc + 1) % 2) == 1;
                2: begin
                    if (stall_start < 0 && beats == 2 * wc + wc / 2) stall_start = cyc + 1;
                    rdy = !(stall_start >= 0 && cyc + 1 < stall_start + 50);
                end
                default: rdy = 1'b1;
            endcase
            step(rdy);
            if (cyc == 1) check("busy_c1", int'(o_busy), 1);
        end
        for (int k = 0; k < 4; k++) step(1'b1);
        check("idle_after_done", int'(o_busy), 0);
    endtask

    typedef struct {
        int cnt;
        int wc;
        int mode;
        int exp_beats;
        int exp_first_ren;
        int exp_first_v;
        int exp_last_beat;
        int exp_done;
    } vec_t;

    vec_t tab [6];

    initial begin
        int snap_beats, snap_reads;
        i_reset = 1'b1; i_start = 1'b0; i_word_count = '0; i_tready = 1'b0;
        for (int b = 0; b < NB; b++) bram_data[b] = '0;

        tab[0] = '{4,    4,    0, 16,   1,  3,  18,   19};
        tab[1] = '{4,    4,    1, 16,   1,  3,  -1,   -1};
        tab[2] = '{0,    0,    0, 0,    -1, -1, -1,   1};
        tab[3] = '{1,    1,    0, 4,    1,  3,  6,    7};
        tab[4] = '{1024, 1024, 2, 4096, 1,  3,  -1,   -1};
        tab[5] = '{1500, 1024, 0, 4096, 1,  3,  4098, 4099};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", int'(o_tvalid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_tdata", int'(o_tdata), 0);
        check("rst_tlast", int'(o_tlast), 0);
        check("rst_raddr", int'(o_raddress), 0);
        for (int b = 0; b < NB; b++) check("rst_ren", int'(o_renable[b]), 0);
        @(negedge clk);
        i_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_drain(tab[i].cnt, tab[i].wc, tab[i].mode);
            check("beats", beats, tab[i].exp_beats);
            check("reads", reads, tab[i].exp_beats);
            check("tlast_count", tlast_cnt, (tab[i].exp_beats > 0) ? 1 : 0);
            check("done_count", done_cnt, 1);
            check("first_ren", first_ren, tab[i].exp_first_ren);
            check("first_valid", first_v, tab[i].exp_first_v);
            if (tab[i].exp_last_beat >= 0) check("last_beat_cyc", last_beat, tab[i].exp_last_beat);
            if (tab[i].exp_done >= 0) check("done_cyc", done_cyc, tab[i].exp_done);
            else check("done_after_last", int'(done_cyc > last_beat), 1);
        end

        // Reset asserted for one cycle while bank1 is being read
        start_pulse(4, 4);
        reset_at = 7;
        while (cyc < 7) step(1'b1);
        reset_at = -100;
        snap_beats = beats; snap_reads = reads;
        step(1'b1);
        check("abort_tvalid", int'(o_tvalid), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        for (int b = 0; b < NB; b++) check("abort_ren", int'(o_renable[b]), 0);
        for (int k = 0; k < 20; k++) step(1'b1);
        check("abort_no_beats", beats, snap_beats);
        check("abort_no_reads", reads, snap_reads);
        check("abort_no_done", done_cnt, 0);
        run_drain(4, 4, 0);
        check("fresh_beats", beats, 16);
        check("fresh_done", done_cnt, 1);
        check("fresh_done_cyc", done_cyc, 19);

        // Second start while busy is ignored
        extra_start = 5;
        run_drain(4, 4, 0);
        extra_start = -100;
        for (int k = 0; k < 10; k++) step(1'b1);
        check("busy_start_beats", beats, 16);
        check("busy_start_reads", reads, 16);
        check("busy_start_done", done_cnt, 1);
        check("busy_start_tlast", tlast_cnt, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
